// File: rtl/pattern_stream_ctrl.sv
// Byte-to-bit scheduler feeding a serial Moore pattern detector with match counting and irq.
// Optional PSC_NONOVERLAP_EN: clear detector history after every match.
module pattern_stream_ctrl #(
    parameter int                   PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]   PATTERN = 5'b11011,
    parameter int                   CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       frame_len,
    input  logic [CNT_W-1:0] threshold,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             irq_clr,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             irq
);

    localparam int VC_W = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]         bytes_left_q, bytes_left_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [7:0]         byte_q, byte_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [VC_W-1:0]    vcnt_q, vcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               irq_q, irq_d;

    logic [PAT_LEN-1:0] shift_hist;
    logic [VC_W-1:0]    shift_vcnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (frame_len == 8'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_idx_q == 3'd0) begin
                    state_d = (bytes_left_q != 8'd0) ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        in_ready = (state_q == S_LOAD);
        done     = (state_q == S_DONE);
    end

    // The detector sees the post-shift history, so a hit is registered one cycle later.
    always_comb begin
        shift_hist = {hist_q[PAT_LEN-2:0], byte_q[bit_idx_q]};
        shift_vcnt = (vcnt_q == VC_W'(PAT_LEN)) ? vcnt_q : vcnt_q + 1'b1;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        hit        = (state_q == S_SHIFT)
                   && (shift_hist == PATTERN)
                   && (shift_vcnt == VC_W'(PAT_LEN));
    end

    always_comb begin
        bytes_left_d = bytes_left_q;
        thr_d        = thr_q;
        byte_d       = byte_q;
        bit_idx_d    = bit_idx_q;
        hist_d       = hist_q;
        vcnt_d       = vcnt_q;
        cnt_d        = cnt_q;
        match_d      = hit;
        irq_d        = irq_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bytes_left_d = frame_len;
                    thr_d        = threshold;
                    hist_d       = '0;
                    vcnt_d       = '0;
                    cnt_d        = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    byte_d       = in_data;
                    bit_idx_d    = 3'd7;
                    bytes_left_d = bytes_left_q - 8'd1;
                end
            end
            S_SHIFT: begin
                hist_d    = shift_hist;
                vcnt_d    = shift_vcnt;
                bit_idx_d = bit_idx_q - 3'd1;
                if (hit) begin
                    cnt_d = cnt_inc;
`ifdef PSC_NONOVERLAP_EN
                    hist_d = '0;
                    vcnt_d = '0;
`endif
                end
            end
            S_DONE: begin
            end
        endcase
        if (irq_clr || (state_q == S_IDLE && start)) begin
            irq_d = 1'b0;
        end
        if (hit && thr_q != '0 && cnt_inc >= thr_q) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_left_q <= '0;
            thr_q        <= '0;
            byte_q       <= '0;
            bit_idx_q    <= '0;
            hist_q       <= '0;
            vcnt_q       <= '0;
            cnt_q        <= '0;
            match_q      <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            bytes_left_q <= bytes_left_d;
            thr_q        <= thr_d;
            byte_q       <= byte_d;
            bit_idx_q    <= bit_idx_d;
            hist_q       <= hist_d;
            vcnt_q       <= vcnt_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            irq_q        <= irq_d;
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Scoreboard bench for pattern_stream_ctrl: bit-list reference model vs. two DUTs (CNT_W=8 and 2).
// Honours PSC_NONOVERLAP_EN in the reference model.
module tb_pattern_stream_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, irq_clr;
    logic [7:0] frame_len, in_data, threshold;
    logic [1:0] threshold2;
    logic       in_ready, busy, match, done, irq;
    logic [7:0] match_count;
    logic       in_ready2, busy2, match2, done2, irq2;
    logic [1:0] match_count2;

    always #5 clk = ~clk;

    pattern_stream_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .threshold(threshold), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .irq_clr(irq_clr), .busy(busy), .match(match),
        .match_count(match_count), .done(done), .irq(irq)
    );

    pattern_stream_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .threshold(threshold2), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .irq_clr(irq_clr), .busy(busy2), .match(match2),
        .match_count(match_count2), .done(done2), .irq(irq2)
    );

    typedef struct {
        int np;
        int c1;
        int c2;
        bit i1;
        bit i2;
    } exp_t;

    exp_t exp_q[$];
    int   exp_pos[$];
    int   got_pos[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: flatten the frame into a bit list (MSB first) and slide a 5-bit window.
    function automatic exp_t model(input logic [7:0] b[$], input int thr,
                                   input int thr2, input bit clrh);
        exp_t e;
        int w = 0, nv = 0, bitn = 0;
        e = '{0, 0, 0, 1'b0, 1'b0};
        foreach (b[k]) begin
            for (int j = 7; j >= 0; j--) begin
                bitn++;
                w = ((w << 1) | int'(b[k][j])) & 31;
                if (nv < 5) nv++;
                if (nv == 5 && w == 27) begin
                    e.np++;
                    exp_pos.push_back(bitn);
                    if (e.c1 < 255) e.c1++;
                    if (e.c2 < 3) e.c2++;
                    if (thr != 0 && e.c1 >= thr) e.i1 = 1'b1;
                    else if (clrh) e.i1 = 1'b0;
                    if (thr2 != 0 && e.c2 >= thr2) e.i2 = 1'b1;
                    else if (clrh) e.i2 = 1'b0;
`ifdef PSC_NONOVERLAP_EN
                    w  = 0;
                    nv = 0;
`endif
                end else if (clrh) begin
                    e.i1 = 1'b0;
                    e.i2 = 1'b0;
                end
            end
        end
        return e;
    endfunction

    int bytes_acc = 0, cyc = 0, rdy_cnt = 0, busy_cyc = 0;
    bit hs_pend = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            got_pos.delete();
            bytes_acc = 0;
            cyc       = 0;
            hs_pend   = 1'b0;
            rdy_cnt   = 0;
            busy_cyc  = 0;
        end else begin
            if (hs_pend) begin
                bytes_acc++;
                cyc     = 0;
                hs_pend = 1'b0;
            end else begin
                cyc++;
            end
            if (busy) busy_cyc++;
            if (in_ready) rdy_cnt++;
            if (match) got_pos.push_back((bytes_acc - 1) * 8 + cyc);
            chk("ready_outside_busy", int'(in_ready && !busy), 0);
            chk("dut2_timing", {busy2, in_ready2, match2, done2},
                {busy, in_ready, match, done});
            if (in_valid && in_ready) hs_pend = 1'b1;
            if (done) begin
                chk("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("count", match_count, e.c1);
                    chk("count_w2", match_count2, e.c2);
                    chk("irq", irq, e.i1);
                    chk("irq_w2", irq2, e.i2);
                    chk("n_matches", got_pos.size(), e.np);
                    for (int i = 0; i < e.np; i++) begin
                        int p;
                        p = exp_pos.pop_front();
                        if (i < got_pos.size()) chk("match_pos", got_pos[i], p);
                    end
                    if (bytes_acc > 0) begin
                        chk("done_latency", cyc, 8);
                    end else begin
                        chk("zero_len_ready", rdy_cnt, 0);
                        chk("zero_len_busy", busy_cyc, 1);
                    end
                end
                got_pos.delete();
                bytes_acc = 0;
                rdy_cnt   = 0;
                busy_cyc  = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", in_ready, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic run_frame(input logic [7:0] b[$], input int thr, input int thr2,
                             input bit clrh, input int stall);
        exp_t e;
        bit   ok;
        e = model(b, thr, thr2, clrh);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start      = 1'b1;
        frame_len  = 8'(b.size());
        threshold  = 8'(thr);
        threshold2 = 2'(thr2);
        irq_clr    = clrh;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (b[k]) begin
            if (stall > 0) begin
                in_valid = 1'b0;
                wait_ready();
                ok = 1'b1;
                repeat (stall) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (!in_ready || match) ok = 1'b0;
                end
                chk("stall_hold", ok, 1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = b[k];
            wait_ready();
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        wait_idle();
        chk("irq_after_frame", irq, clrh ? 0 : int'(e.i1));
        @(posedge clk); #1;
        irq_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
        q.delete();
    end

    initial begin
        logic [7:0] q[$];
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; irq_clr = 1'b0;
        frame_len = 8'd0; in_data = 8'd0; threshold = 8'd0; threshold2 = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {busy, in_ready, match, done, irq, match_count}, 0);
        chk("rst_outs_w2", {busy2, in_ready2, match2, done2, irq2, match_count2}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        q = '{8'hDB};
        run_frame(q, 2, 2, 1'b0, 0);
        q = '{8'h03, 8'h60};
        run_frame(q, 1, 1, 1'b0, 0);
        q.delete();
        run_frame(q, 1, 1, 1'b0, 0);
        q = '{8'hDB, 8'h6D};
        run_frame(q, 3, 2, 1'b0, 10);
        run_frame(q, 3, 2, 1'b0, 0);
        q = '{8'hDB, 8'hDB, 8'hDB, 8'hDB};
        run_frame(q, 3, 3, 1'b1, 0);

        @(posedge clk); #1;
        start = 1'b1; frame_len = 8'd3; threshold = 8'd1; threshold2 = 2'd1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'hDB;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {busy, in_ready, match, done, irq, match_count}, 0);
        chk("midrst_w2", {busy2, match2, done2, irq2, match_count2}, 0);
        repeat (12) @(negedge clk);
        q = '{8'h1B, 8'h6C};
        run_frame(q, 1, 1, 1'b0, 0);

        for (int f = 0; f < 40; f++) begin
            int n;
            q.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: q.push_back(8'hDB);
                    1: q.push_back(8'h1B);
                    2: q.push_back(8'hB6);
                    default: q.push_back(8'($urandom));
                endcase
            end
            run_frame(q, $urandom_range(0, 4), $urandom_range(0, 3), 1'b0,
                      ($urandom_range(0, 3) == 0) ? 12 : 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
